spi_reg_bridge: RTL and testbench
=================================

Name: spi_reg_bridge

Overview:
- Byte-level command decoder between the `spi` shift engine and an on-chip register bank.
- Consumes received bytes (`out_buffer`/`out_strobe`) and decodes read/write frames with address auto-increment.
- Drives a simple synchronous register bus.
- Returns read data to `spi` through the `in_buffer` valid/ready handshake.
- Runs in the SPI clock domain, one clock.

Parameters:
- DATA_BITS, 8, byte width; equals spi OUT_BUFFER_BITS and IN_BUFFER_BITS.
- ADDR_BITS, 7, register address width; must equal DATA_BITS-1.

Ports:
- clk  in  1  SPI clock, shared with spi.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- cs  in  1  chip select, active-low; high = frame boundary.
- rx_data  in  DATA_BITS  from spi out_buffer.
- rx_strobe  in  1  from spi out_strobe; one-cycle pulse per received byte.
- tx_data  out  DATA_BITS  to spi in_buffer.
- tx_valid  out  1  to spi in_buffer_valid.
- tx_ready  in  1  from spi in_buffer_ready.
- reg_addr  out  ADDR_BITS  register bus address.
- reg_wdata  out  DATA_BITS  register bus write data.
- reg_we  out  1  write pulse, one cycle.
- reg_re  out  1  read pulse, one cycle.
- reg_rdata  in  DATA_BITS  read data, valid exactly one cycle after reg_re.

Behaviour:
- Reset (async, reset=0): state=IDLE, addr=0, tx_data=0, tx_valid=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0.
- Frame format:
  - First byte after cs falls is CMD: bit[DATA_BITS-1] = 1 for read, 0 for write; bits[ADDR_BITS-1:0] = start address.
  - Write frame: every later byte is data.
  - Read frame: later bytes are dummy and ignored.
- States: IDLE, WR_DATA, RD_REQ, RD_WAIT, RD_PRESENT.
- IDLE:
  - rx_strobe with cs=0 latches addr = rx_data[ADDR_BITS-1:0].
  - Write command → WR_DATA.
  - Read command → RD_REQ.
- WR_DATA: on rx_strobe, in the next cycle drive reg_we=1, reg_addr=addr, reg_wdata=rx_data. Then addr=addr+1. Stay in WR_DATA.
- RD_REQ: reg_re=1 and reg_addr=addr for one cycle → RD_WAIT.
- RD_WAIT: capture tx_data=reg_rdata, set tx_valid=1 → RD_PRESENT.
- RD_PRESENT:
  - Hold tx_data and tx_valid until tx_valid&tx_ready is sampled.
  - The following cycle: tx_valid=0, addr=addr+1 → RD_REQ, which prefetches the next byte.
- Address arithmetic is modulo 2^ADDR_BITS: 0x7F+1 wraps to 0x00.
- rx_strobe in any RD_* state is ignored; it is the dummy byte.
- cs=1 sampled on any edge:
  - State → IDLE; tx_valid, reg_we, reg_re cleared next cycle.
  - addr is kept but is meaningless.
  - A pending read byte is dropped.
  - cs=1 has priority over a simultaneous rx_strobe; that byte is discarded.
- Latency:
  - rx_strobe → reg_we is 1 cycle.
  - CMD strobe → tx_valid is 3 cycles (RD_REQ, RD_WAIT, RD_PRESENT).
  - The first read byte is shifted out on the byte after CMD. This is the prefetch budget; DATA_BITS ≥ 4 guarantees margin.
- Reset asserted mid-frame forces all outputs to their reset values immediately. After release, the FSM waits in IDLE, and the next strobe is treated as CMD even if cs stayed low.
- reg_we and reg_re are never high in the same cycle.

Decomposition:
- Package spi_bridge_pkg holds:
  - state enum (IDLE, WR_DATA, RD_REQ, RD_WAIT, RD_PRESENT)
  - CMD_READ_BIT = DATA_BITS-1
  - default widths
- No sub-module: a single FSM plus the address counter is natural.

Test Plan:
- Reset: hold reset=0 → all outputs 0, state IDLE. Release with cs=1 → outputs stay 0.
- Single write: cs=0; strobes 0x05 then 0xA5 → one reg_we pulse with reg_addr=0x05, reg_wdata=0xA5, 1 cycle after the second strobe.
- Burst write with wrap: CMD 0x7E, data 0x11, 0x22, 0x33 → writes (0x7E,0x11), (0x7F,0x22), (0x00,0x33).
- Read burst: bank holds 0x10→0x3C, 0x11→0xC3. Send CMD 0x90, then pulse tx_ready once per byte:
  - tx_data=0x3C with tx_valid 3 cycles after CMD.
  - After the handshake, reg_re at 0x11, then tx_data=0xC3.
- Abort: read CMD, then cs=1 while tx_valid=1 and tx_ready=0 → tx_valid=0 next cycle, state IDLE. The next frame, CMD 0x02 then data 0x44, produces a write at 0x02.
- Collision: cs rises in the same cycle as rx_strobe during WR_DATA → no reg_we pulse; the FSM returns to IDLE.

Source files
------------

// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI byte-to-register-bus bridge.
package spi_bridge_pkg;

    // Default byte width; matches the spi shift engine buffer width.
    localparam int DEF_DATA_BITS = 8;
    // Register address width: the command byte minus its read/write flag.
    localparam int DEF_ADDR_BITS = DEF_DATA_BITS - 1;
    // Position of the read flag inside the command byte.
    localparam int CMD_READ_BIT  = DEF_DATA_BITS - 1;

    // Bridge FSM states.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WR_DATA    = 3'd1,
        RD_REQ     = 3'd2,
        RD_WAIT    = 3'd3,
        RD_PRESENT = 3'd4
    } state_t;

endpackage

// File: rtl/spi_reg_bridge.sv
// Byte-level command decoder between the spi shift engine and a register bank.
// The first byte of a frame (cs low) is a command: MSB=1 read, MSB=0 write,
// low bits = start address. Write frames turn each later byte into a register
// write; read frames prefetch register bytes and offer them to spi. Both
// directions auto-increment the address modulo 2^ADDR_BITS.
//
// tx handshake: tx_valid rises with tx_data and both stay stable until a clock
// edge samples tx_valid & tx_ready high; the byte is consumed on that edge.
module spi_reg_bridge
    import spi_bridge_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cs,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_strobe,
    output logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [ADDR_BITS-1:0] reg_addr,
    output logic [DATA_BITS-1:0] reg_wdata,
    output logic                 reg_we,
    output logic                 reg_re,
    input  logic [DATA_BITS-1:0] reg_rdata,
    output state_t               state_dbg
);

    // Read flag position for this instance's byte width.
    localparam int READ_BIT = DATA_BITS - 1;

    state_t                 state_q,     state_d;
    logic [ADDR_BITS-1:0]   addr_q,      addr_d;
    logic [DATA_BITS-1:0]   tx_data_q,   tx_data_d;
    logic                   tx_valid_q,  tx_valid_d;
    logic [ADDR_BITS-1:0]   reg_addr_q,  reg_addr_d;
    logic [DATA_BITS-1:0]   reg_wdata_q, reg_wdata_d;
    logic                   reg_we_q,    reg_we_d;
    logic                   reg_re_q,    reg_re_d;

    // State and registered outputs; async active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
        end
    end

    // Next-state, address counter and bus-output decode.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;

        if (cs) begin
            // Frame boundary wins over everything, including a same-cycle
            // strobe; any pending read byte is dropped.
            state_d    = IDLE;
            tx_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_strobe) begin
                        addr_d  = rx_data[ADDR_BITS-1:0];
                        state_d = rx_data[READ_BIT] ? RD_REQ : WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (rx_strobe) begin
                        reg_we_d    = 1'b1;
                        reg_addr_d  = addr_q;
                        reg_wdata_d = rx_data;
                        addr_d      = addr_q + ADDR_BITS'(1);
                    end
                end
                RD_REQ: begin
                    state_d = RD_WAIT;
                end
                RD_WAIT: begin
                    // reg_rdata is valid now, one cycle after the reg_re pulse.
                    tx_data_d  = reg_rdata;
                    tx_valid_d = 1'b1;
                    state_d    = RD_PRESENT;
                end
                RD_PRESENT: begin
                    if (tx_valid_q && tx_ready) begin
                        tx_valid_d = 1'b0;
                        addr_d     = addr_q + ADDR_BITS'(1);
                        state_d    = RD_REQ;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // The read pulse lives exactly in the RD_REQ cycle, so it is
            // armed on every entry into RD_REQ with the address in use there.
            if (state_d == RD_REQ) begin
                reg_re_d   = 1'b1;
                reg_addr_d = addr_d;
            end
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: reset, writes, wrap, read burst,
// abort, strobe/cs collision and mid-frame reset.
module tb_spi_reg_bridge;
  import spi_bridge_pkg::*;

  logic       clk;
  logic       reset;
  logic       cs;
  logic [7:0] rx_data;
  logic       rx_strobe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  state_t     state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] bank [0:127];

  spi_reg_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .rx_data   (rx_data),
    .rx_strobe (rx_strobe),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register bank model: data valid exactly one cycle after reg_re,
  // a poison value otherwise so mistimed captures show up
  always @(posedge clk) begin
    if (reg_re) reg_rdata <= bank[reg_addr];
    else        reg_rdata <= 8'hEE;
  end

  // reg_we and reg_re must never overlap
  always @(negedge clk) begin
    n_checks++;
    if (reg_we && reg_re) begin
      n_fail++;
      $display("FAIL we_re_overlap: got we=%b re=%b expected not both 1", reg_we, reg_re);
    end
  end

  // driver tasks (called at a negedge, return at a negedge)
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data   = b;
    rx_strobe = 1'b1;
    @(negedge clk);
    rx_strobe = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; cs = 1'b1; rx_data = 8'h00; rx_strobe = 1'b0; tx_ready = 1'b0;
    tick(); tick();
    n_checks++;
    if ({tx_data, tx_valid, reg_addr, reg_wdata, reg_we, reg_re} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h/%b/%h/%h/%b/%b expected all zero",
               tx_data, tx_valid, reg_addr, reg_wdata, reg_we, reg_re);
    end
    n_checks++;
    if (state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE);
    end
    reset = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if ({tx_data, tx_valid, reg_addr, reg_wdata, reg_we, reg_re, state_dbg} !== {25'd0, IDLE}) begin
      n_fail++;
      $display("FAIL reset_release: got %h/%b/%h/%h/%b/%b st=%0d expected all zero, IDLE",
               tx_data, tx_valid, reg_addr, reg_wdata, reg_we, reg_re, state_dbg);
    end
  endtask

  task automatic test_single_write();
    cs = 1'b0; tick();
    send_byte(8'h05);
    n_checks++;
    if ({state_dbg, reg_we} !== {WR_DATA, 1'b0}) begin
      n_fail++;
      $display("FAIL wr_cmd: got st=%0d we=%b expected st=%0d we=0", state_dbg, reg_we, WR_DATA);
    end
    tick(); tick();
    send_byte(8'hA5);
    n_checks++;
    if ({reg_we, reg_addr, reg_wdata} !== {1'b1, 7'h05, 8'hA5}) begin
      n_fail++;
      $display("FAIL wr_single: got we=%b addr=%h data=%h expected we=1 addr=05 data=a5",
               reg_we, reg_addr, reg_wdata);
    end
    tick();
    n_checks++;
    if (reg_we !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_single_pulse: got we=%b expected 0", reg_we);
    end
    cs = 1'b1; tick(); tick();
  endtask

  task automatic test_burst_wrap();
    logic [6:0] exp_a [3];
    logic [7:0] exp_d [3];
    exp_a[0] = 7'h7E; exp_a[1] = 7'h7F; exp_a[2] = 7'h00;
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    cs = 1'b0; tick();
    send_byte(8'h7E);
    for (int i = 0; i < 3; i++) begin
      tick();
      send_byte(exp_d[i]);
      n_checks++;
      if ({reg_we, reg_addr, reg_wdata} !== {1'b1, exp_a[i], exp_d[i]}) begin
        n_fail++;
        $display("FAIL wr_burst[%0d]: got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                 i, reg_we, reg_addr, reg_wdata, exp_a[i], exp_d[i]);
      end
    end
    cs = 1'b1; tick(); tick();
  endtask

  task automatic test_read_burst();
    cs = 1'b0; tick();
    send_byte(8'h90);
    n_checks++;
    if ({state_dbg, reg_re, reg_addr, tx_valid} !== {RD_REQ, 1'b1, 7'h10, 1'b0}) begin
      n_fail++;
      $display("FAIL rd_req0: got st=%0d re=%b addr=%h v=%b expected st=%0d re=1 addr=10 v=0",
               state_dbg, reg_re, reg_addr, tx_valid, RD_REQ);
    end
    tick();
    n_checks++;
    if ({state_dbg, reg_re, tx_valid} !== {RD_WAIT, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rd_wait0: got st=%0d re=%b v=%b expected st=%0d re=0 v=0",
               state_dbg, reg_re, tx_valid, RD_WAIT);
    end
    tick();
    n_checks++;
    if ({state_dbg, tx_valid, tx_data} !== {RD_PRESENT, 1'b1, 8'h3C}) begin
      n_fail++;
      $display("FAIL rd_byte0: got st=%0d v=%b data=%h expected st=%0d v=1 data=3c",
               state_dbg, tx_valid, tx_data, RD_PRESENT);
    end
    tick(); tick();
    send_byte(8'hFF);
    n_checks++;
    if ({state_dbg, tx_valid, tx_data} !== {RD_PRESENT, 1'b1, 8'h3C}) begin
      n_fail++;
      $display("FAIL rd_hold: got st=%0d v=%b data=%h expected st=%0d v=1 data=3c",
               state_dbg, tx_valid, tx_data, RD_PRESENT);
    end
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    n_checks++;
    if ({state_dbg, tx_valid, reg_re, reg_addr} !== {RD_REQ, 1'b0, 1'b1, 7'h11}) begin
      n_fail++;
      $display("FAIL rd_req1: got st=%0d v=%b re=%b addr=%h expected st=%0d v=0 re=1 addr=11",
               state_dbg, tx_valid, reg_re, reg_addr, RD_REQ);
    end
    tick(); tick();
    n_checks++;
    if ({tx_valid, tx_data} !== {1'b1, 8'hC3}) begin
      n_fail++;
      $display("FAIL rd_byte1: got v=%b data=%h expected v=1 data=c3", tx_valid, tx_data);
    end
    cs = 1'b1; tick();
    n_checks++;
    if ({state_dbg, tx_valid, reg_re} !== {IDLE, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rd_end: got st=%0d v=%b re=%b expected st=%0d v=0 re=0",
               state_dbg, tx_valid, reg_re, IDLE);
    end
    tick();
  endtask

  task automatic test_abort();
    cs = 1'b0; tick();
    send_byte(8'hC5);
    tick(); tick();
    n_checks++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h5A}) begin
      n_fail++;
      $display("FAIL abort_pre: got v=%b data=%h expected v=1 data=5a", tx_valid, tx_data);
    end
    cs = 1'b1; tick();
    n_checks++;
    if ({state_dbg, tx_valid} !== {IDLE, 1'b0}) begin
      n_fail++;
      $display("FAIL abort: got st=%0d v=%b expected st=%0d v=0", state_dbg, tx_valid, IDLE);
    end
    tick();
    cs = 1'b0; tick();
    send_byte(8'h02);
    send_byte(8'h44);
    n_checks++;
    if ({reg_we, reg_addr, reg_wdata} !== {1'b1, 7'h02, 8'h44}) begin
      n_fail++;
      $display("FAIL abort_next_wr: got we=%b addr=%h data=%h expected we=1 addr=02 data=44",
               reg_we, reg_addr, reg_wdata);
    end
    cs = 1'b1; tick(); tick();
  endtask

  task automatic test_collision();
    cs = 1'b0; tick();
    send_byte(8'h20);
    tick();
    cs = 1'b1;
    send_byte(8'h99);
    n_checks++;
    if ({reg_we, state_dbg} !== {1'b0, IDLE}) begin
      n_fail++;
      $display("FAIL collision: got we=%b st=%0d expected we=0 st=%0d", reg_we, state_dbg, IDLE);
    end
    tick();
  endtask

  task automatic test_reset_midframe();
    cs = 1'b0; tick();
    send_byte(8'h30);
    send_byte(8'h66);
    n_checks++;
    if ({reg_we, reg_addr, reg_wdata} !== {1'b1, 7'h30, 8'h66}) begin
      n_fail++;
      $display("FAIL mid_pre_wr: got we=%b addr=%h data=%h expected we=1 addr=30 data=66",
               reg_we, reg_addr, reg_wdata);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({reg_we, reg_addr, reg_wdata, state_dbg} !== {16'd0, IDLE}) begin
      n_fail++;
      $display("FAIL mid_reset_async: got we=%b addr=%h data=%h st=%0d expected zeros IDLE",
               reg_we, reg_addr, reg_wdata, state_dbg);
    end
    tick();
    reset = 1'b1;
    tick();
    send_byte(8'h03);
    n_checks++;
    if (state_dbg !== WR_DATA) begin
      n_fail++;
      $display("FAIL mid_reset_cmd: got st=%0d expected %0d", state_dbg, WR_DATA);
    end
    send_byte(8'h55);
    n_checks++;
    if ({reg_we, reg_addr, reg_wdata} !== {1'b1, 7'h03, 8'h55}) begin
      n_fail++;
      $display("FAIL mid_reset_wr: got we=%b addr=%h data=%h expected we=1 addr=03 data=55",
               reg_we, reg_addr, reg_wdata);
    end
    cs = 1'b1; tick();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) bank[i] = 8'h00;
    bank[7'h10] = 8'h3C;
    bank[7'h11] = 8'hC3;
    bank[7'h45] = 8'h5A;
    test_reset();
    test_single_write();
    test_burst_wrap();
    test_read_burst();
    test_abort();
    test_collision();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
